// File: rtl/enemy_wave_controller_pkg.sv
// Shared playfield geometry and wave FSM encoding for the enemy wave controller.
package enemy_wave_controller_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE   = 32;

  typedef enum logic [1:0] {
    W_RUN   = 2'd0,
    W_WAIT  = 2'd1,
    W_SPAWN = 2'd2
  } wave_state_t;

endpackage

// File: rtl/enemy_wave_controller_if.sv
// Bus between the collision checker / renderer side and the enemy wave controller.
interface enemy_wave_controller_if #(
  parameter int N_ENEMY = 4,
  parameter int COORD_W = enemy_wave_controller_pkg::COORD_W
);
  logic                         frame_tick;
  logic                         pause;
  logic [N_ENEMY-1:0]           hit_mask;
  logic [N_ENEMY*COORD_W-1:0]   enemy_x_flat;
  logic [N_ENEMY*COORD_W-1:0]   enemy_y_flat;
  logic [N_ENEMY-1:0]           enemy_alive;
  logic [N_ENEMY-1:0]           kill_pulse;
  logic [N_ENEMY-1:0]           escape_pulse;
  logic [7:0]                   wave_num;
  logic                         wave_clear;

  modport master (
    output frame_tick, pause, hit_mask,
    input  enemy_x_flat, enemy_y_flat, enemy_alive, kill_pulse, escape_pulse,
           wave_num, wave_clear
  );

  modport slave (
    input  frame_tick, pause, hit_mask,
    output enemy_x_flat, enemy_y_flat, enemy_alive, kill_pulse, escape_pulse,
           wave_num, wave_clear
  );
endinterface

// File: rtl/enemy_wave_controller_enemy_mover.sv
// One enemy sprite: diagonal motion with wall bounce/clamp, bottom escape and hit kill.
module enemy_mover #(
  parameter int COORD_W   = enemy_wave_controller_pkg::COORD_W,
  parameter int SCREEN_W  = enemy_wave_controller_pkg::SCREEN_W,
  parameter int SCREEN_H  = enemy_wave_controller_pkg::SCREEN_H,
  parameter int SPRITE    = enemy_wave_controller_pkg::SPRITE,
  parameter int SPEED_X   = 2,
  parameter int SPAWN_X   = 0,
  parameter bit SPAWN_NEG = 1'b0
) (
  input  logic               clk25,
  input  logic               reset_enemy,
  input  logic               tick,
  input  logic               spawn,
  input  logic               hit,
  input  logic [COORD_W-1:0] dy,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               alive,
  output logic               kill_pulse,
  output logic               escape_pulse
);

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] X_MAX  = SW'(SCREEN_W - SPRITE);
  localparam logic signed [SW-1:0] Y_LIM  = SW'(SCREEN_H - SPRITE);
  localparam logic signed [SW-1:0] STEP_X = SW'(SPEED_X);

  logic                 dir_neg;
  logic signed [SW-1:0] dx;
  logic signed [SW-1:0] nx;
  logic signed [SW-1:0] ny;

  assign dx = dir_neg ? -STEP_X : STEP_X;
  assign nx = $signed({2'b00, x}) + dx;
  assign ny = $signed({2'b00, y}) + $signed({2'b00, dy});

  always_ff @(posedge clk25 or posedge reset_enemy) begin
    if (reset_enemy) begin
      x            <= COORD_W'(SPAWN_X);
      y            <= '0;
      dir_neg      <= SPAWN_NEG;
      alive        <= 1'b1;
      kill_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
    end else begin
      kill_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
      if (spawn) begin
        x       <= COORD_W'(SPAWN_X);
        y       <= '0;
        dir_neg <= SPAWN_NEG;
        alive   <= 1'b1;
      end else if (alive) begin
        // A hit outranks the frame's motion, so a simultaneous escape never reports.
        if (hit) begin
          alive      <= 1'b0;
          kill_pulse <= 1'b1;
        end else if (tick) begin
          if (nx <= ZERO) begin
            x       <= '0;
            dir_neg <= 1'b0;
          end else if (nx >= X_MAX) begin
            x       <= X_MAX[COORD_W-1:0];
            dir_neg <= 1'b1;
          end else begin
            x <= nx[COORD_W-1:0];
          end
          if (ny >= Y_LIM) begin
            alive        <= 1'b0;
            escape_pulse <= 1'b1;
          end else begin
            y <= ny[COORD_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/enemy_wave_controller.sv
// Wave controller: N_ENEMY movers plus the clear/wait/respawn FSM with per-wave speed-up.
module enemy_wave_controller #(
  parameter int N_ENEMY        = 4,
  parameter int COORD_W        = enemy_wave_controller_pkg::COORD_W,
  parameter int SCREEN_W       = enemy_wave_controller_pkg::SCREEN_W,
  parameter int SCREEN_H       = enemy_wave_controller_pkg::SCREEN_H,
  parameter int SPRITE         = enemy_wave_controller_pkg::SPRITE,
  parameter int SPEED_X        = 2,
  parameter int SPEED_Y        = 2,
  parameter int MAX_BOOST      = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                    clk25,
  input  logic                    reset_enemy,
  enemy_wave_controller_if.slave  bus
);

  import enemy_wave_controller_pkg::wave_state_t;
  import enemy_wave_controller_pkg::W_RUN;
  import enemy_wave_controller_pkg::W_WAIT;
  import enemy_wave_controller_pkg::W_SPAWN;

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int SLOT  = SCREEN_W / N_ENEMY;

  wave_state_t                state, state_nx;
  logic [CNT_W-1:0]           frame_cnt, frame_cnt_nx;
  logic [7:0]                 wave_num, wave_num_nx;
  logic                       spawn;
  logic                       tick;
  logic [7:0]                 boost;
  logic [COORD_W-1:0]         dy;
  logic [N_ENEMY*COORD_W-1:0] x_flat;
  logic [N_ENEMY*COORD_W-1:0] y_flat;
  logic [N_ENEMY-1:0]         alive;
  logic [N_ENEMY-1:0]         kill;
  logic [N_ENEMY-1:0]         escape;

  assign tick  = bus.frame_tick & ~bus.pause;
  assign boost = (wave_num > 8'(MAX_BOOST)) ? 8'(MAX_BOOST) : wave_num;
  assign dy    = COORD_W'(SPEED_Y) + COORD_W'(boost);

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    enemy_mover #(
      .COORD_W   (COORD_W),
      .SCREEN_W  (SCREEN_W),
      .SCREEN_H  (SCREEN_H),
      .SPRITE    (SPRITE),
      .SPEED_X   (SPEED_X),
      .SPAWN_X   (SLOT * i + (SLOT - SPRITE) / 2),
      .SPAWN_NEG (i % 2 == 1)
    ) u_mover (
      .clk25        (clk25),
      .reset_enemy  (reset_enemy),
      .tick         (tick),
      .spawn        (spawn),
      .hit          (bus.hit_mask[i]),
      .dy           (dy),
      .x            (x_flat[i*COORD_W +: COORD_W]),
      .y            (y_flat[i*COORD_W +: COORD_W]),
      .alive        (alive[i]),
      .kill_pulse   (kill[i]),
      .escape_pulse (escape[i])
    );
  end

  always_ff @(posedge clk25 or posedge reset_enemy) begin
    if (reset_enemy) begin
      state     <= W_RUN;
      frame_cnt <= '0;
      wave_num  <= '0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      wave_num  <= wave_num_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    wave_num_nx  = wave_num;
    spawn        = 1'b0;
    case (state)
      W_RUN: begin
        if (alive == '0) begin
          state_nx     = W_WAIT;
          frame_cnt_nx = CNT_W'(RESPAWN_FRAMES);
        end
      end
      W_WAIT: begin
        if (tick) begin
          if (frame_cnt == '0) state_nx = W_SPAWN;
          else                 frame_cnt_nx = frame_cnt - 1'b1;
        end
      end
      W_SPAWN: begin
        spawn       = 1'b1;
        wave_num_nx = (wave_num == 8'hFF) ? wave_num : wave_num + 8'd1;
        state_nx    = W_RUN;
      end
      default: state_nx = W_RUN;
    endcase
  end

  assign bus.enemy_x_flat = x_flat;
  assign bus.enemy_y_flat = y_flat;
  assign bus.enemy_alive  = alive;
  assign bus.kill_pulse   = kill;
  assign bus.escape_pulse = escape;
  assign bus.wave_num     = wave_num;
  assign bus.wave_clear   = (state == W_WAIT);

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Directed bench for enemy_wave_controller with hand-computed expectations (default parameters).
module tb_enemy_wave_controller;

  logic clk25 = 1'b0;
  logic reset_enemy;
  int   n_cmp = 0;
  int   n_err = 0;

  always #20 clk25 = ~clk25;

  enemy_wave_controller_if #(.N_ENEMY(4), .COORD_W(10)) bus ();

  enemy_wave_controller dut (
    .clk25       (clk25),
    .reset_enemy (reset_enemy),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic next_wave(input int exp_wave);
    bus.hit_mask = 4'b1111;
    step();
    bus.hit_mask = 4'b0000;
    step();
    repeat (61) do_tick();
    step();
    check("wave_num_next", 64'(bus.wave_num), 64'(exp_wave));
    check("alive_next", 64'(bus.enemy_alive), 64'(4'b1111));
  endtask

  initial begin
    reset_enemy      = 1'b1;
    bus.frame_tick   = 1'b0;
    bus.pause        = 1'b0;
    bus.hit_mask     = 4'b0000;
    repeat (2) step();
    check("rst_x", 64'(bus.enemy_x_flat), 64'(pk(64, 224, 384, 544)));
    check("rst_y", 64'(bus.enemy_y_flat), 64'(pk(0, 0, 0, 0)));
    check("rst_alive", 64'(bus.enemy_alive), 64'(4'b1111));
    check("rst_pulses", 64'({bus.kill_pulse, bus.escape_pulse}), 64'(0));
    check("rst_wave", 64'({bus.wave_num, bus.wave_clear}), 64'(0));
    reset_enemy = 1'b0;
    step();

    do_tick();
    check("tick1_x", 64'(bus.enemy_x_flat), 64'(pk(66, 222, 386, 542)));
    check("tick1_y", 64'(bus.enemy_y_flat), 64'(pk(2, 2, 2, 2)));
    check("tick1_alive", 64'(bus.enemy_alive), 64'(4'b1111));
    check("tick1_wave", 64'(bus.wave_num), 64'(0));

    // Enemy 1 reaches the left wall and enemy 2 the right wall on tick 112.
    repeat (111) do_tick();
    check("wall_x", 64'(bus.enemy_x_flat), 64'(pk(288, 0, 608, 320)));
    do_tick();
    check("bounce_x", 64'(bus.enemy_x_flat), 64'(pk(290, 2, 606, 318)));
    check("bounce_y", 64'(bus.enemy_y_flat), 64'(pk(226, 226, 226, 226)));

    bus.hit_mask = 4'b0100;
    step();
    check("hit_alive", 64'(bus.enemy_alive), 64'(4'b1011));
    check("hit_kill", 64'(bus.kill_pulse), 64'(4'b0100));
    step();
    check("rehit_kill", 64'(bus.kill_pulse), 64'(0));
    check("rehit_alive", 64'(bus.enemy_alive), 64'(4'b1011));
    bus.hit_mask = 4'b0000;

    bus.pause = 1'b1;
    do_tick();
    check("pause_y", 64'(bus.enemy_y_flat), 64'(pk(226, 226, 226, 226)));
    bus.pause = 1'b0;

    repeat (110) do_tick();
    check("pre_escape_y", 64'(bus.enemy_y_flat), 64'(pk(446, 446, 226, 446)));

    bus.hit_mask = 4'b0001;
    do_tick();
    bus.hit_mask = 4'b0000;
    check("prio_kill", 64'(bus.kill_pulse), 64'(4'b0001));
    check("escape", 64'(bus.escape_pulse), 64'(4'b1010));
    check("escape_alive", 64'(bus.enemy_alive), 64'(0));
    check("escape_y", 64'(bus.enemy_y_flat), 64'(pk(446, 446, 226, 446)));
    step();
    check("pulse_width", 64'({bus.kill_pulse, bus.escape_pulse}), 64'(0));
    check("wave_clear", 64'(bus.wave_clear), 64'(1));

    repeat (30) do_tick();
    bus.pause = 1'b1;
    repeat (10) do_tick();
    bus.pause = 1'b0;
    repeat (30) do_tick();
    check("wait_clear", 64'(bus.wave_clear), 64'(1));
    check("wait_alive", 64'(bus.enemy_alive), 64'(0));
    do_tick();
    check("spawn_state_alive", 64'(bus.enemy_alive), 64'(0));
    step();
    check("spawn_alive", 64'(bus.enemy_alive), 64'(4'b1111));
    check("spawn_wave", 64'(bus.wave_num), 64'(1));
    check("spawn_x", 64'(bus.enemy_x_flat), 64'(pk(64, 224, 384, 544)));
    check("spawn_y", 64'(bus.enemy_y_flat), 64'(pk(0, 0, 0, 0)));
    check("spawn_clear", 64'(bus.wave_clear), 64'(0));
    do_tick();
    check("w1_y", 64'(bus.enemy_y_flat), 64'(pk(3, 3, 3, 3)));

    next_wave(2);
    do_tick();
    check("w2_y", 64'(bus.enemy_y_flat), 64'(pk(4, 4, 4, 4)));
    next_wave(3);
    do_tick();
    check("w3_y", 64'(bus.enemy_y_flat), 64'(pk(5, 5, 5, 5)));
    next_wave(4);
    do_tick();
    check("w4_y", 64'(bus.enemy_y_flat), 64'(pk(5, 5, 5, 5)));

    bus.hit_mask = 4'b1111;
    step();
    bus.hit_mask = 4'b0000;
    step();
    check("arst_pre_clear", 64'(bus.wave_clear), 64'(1));
    repeat (5) do_tick();
    #5;
    reset_enemy = 1'b1;
    #1;
    check("arst_alive", 64'(bus.enemy_alive), 64'(4'b1111));
    check("arst_wave", 64'({bus.wave_num, bus.wave_clear}), 64'(0));
    check("arst_x", 64'(bus.enemy_x_flat), 64'(pk(64, 224, 384, 544)));
    check("arst_y", 64'(bus.enemy_y_flat), 64'(pk(0, 0, 0, 0)));
    repeat (2) step();
    reset_enemy = 1'b0;
    do_tick();
    check("post_rst_y", 64'(bus.enemy_y_flat), 64'(pk(2, 2, 2, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
